ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable. It drives the bidirectional PS/2 clock and data lines through open-drain enables and sits beside the existing PS/2 receiver on the same pins. It generates the request-to-send sequence, shifts the frame on device-generated clock edges, and checks the device ACK.

---
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift on device clock
// falls, ACK check and overall timeout. Drives the pins via open-drain enables.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iSend,
   input  logic [7:0] iData,
   input  logic       iPS2_clk,
   input  logic       iPS2_data,
   output logic       oPS2_clk_oe,
   output logic       oPS2_data_oe,
   output logic       oBusy,
   output logic       oDone,
   output logic       oError
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic             r_clk_meta, r_clk_sync, r_clk_prev;
   logic             r_data_meta, r_data_sync;
   logic [2:0]       r_state;
   logic [INH_W-1:0] r_inh_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic [3:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_parity;
   logic             r_clk_oe, r_data_oe, r_busy, r_done, r_error;

   logic w_fall;
   logic w_timeout;

   assign w_fall    = r_clk_prev & ~r_clk_sync;
   assign w_timeout = (r_state != S_IDLE) && (r_tmo == TMO_LAST);

   // Pins are asynchronous to iCLK; two flops before any decision is taken.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_clk_meta  <= 1'b0;
         r_clk_sync  <= 1'b0;
         r_clk_prev  <= 1'b0;
         r_data_meta <= 1'b0;
         r_data_sync <= 1'b0;
      end else begin
         r_clk_meta  <= iPS2_clk;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= iPS2_data;
         r_data_sync <= r_data_meta;
      end
   end

   // NOTE: all state uses <= so every branch reads pre-edge values; later
   // assignments in the same block deliberately override earlier defaults.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state   <= S_IDLE;
         r_inh_cnt <= '0;
         r_tmo     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (r_state != S_IDLE) r_tmo <= r_tmo + 1'b1;

         if (w_timeout) begin
            r_state   <= S_IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (iSend) begin
                     r_shift   <= iData;
                     r_parity  <= ~^iData;
                     r_tmo     <= '0;
                     r_inh_cnt <= '0;
                     r_busy    <= 1'b1;
                     r_clk_oe  <= 1'b1;
                     r_data_oe <= 1'b0;
                     r_state   <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (r_inh_cnt == INH_LAST) begin
                     r_data_oe <= 1'b1;
                     r_state   <= S_START;
                  end else begin
                     r_inh_cnt <= r_inh_cnt + 1'b1;
                  end
               end
               S_START: begin
                  r_clk_oe  <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= S_SEND;
               end
               S_SEND: begin
                  // Count n is the post-increment value: 1..8 data, 9 parity, 10 stop.
                  if (w_fall) begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt < 4'd8) begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= r_shift >> 1;
                     end else if (r_bit_cnt == 4'd8) begin
                        r_data_oe <= ~r_parity;
                     end else begin
                        r_data_oe <= 1'b0;
                        r_state   <= S_ACK;
                     end
                  end
               end
               S_ACK: begin
                  if (w_fall) begin
                     if (r_data_sync) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= S_WAIT_IDLE;
                     end
                  end
               end
               S_WAIT_IDLE: begin
                  if (r_clk_sync && r_data_sync) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state   <= S_IDLE;
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign oPS2_clk_oe  = r_clk_oe;
   assign oPS2_data_oe = r_data_oe;
   assign oBusy        = r_busy;
   assign oDone        = r_done;
   assign oError       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain bus model, PS/2 device model
// and a frame reference built from the byte's bits and odd parity.
module tb_ps2_host_tx;

   localparam int INH = 50;
   localparam int TMO = 3000;

   logic       iCLK = 1'b0;
   logic       iRST, iSend;
   logic [7:0] iData;
   logic       dev_clk, dev_data;
   logic       w_ps2_clk, w_ps2_data;
   logic       oPS2_clk_oe, oPS2_data_oe, oBusy, oDone, oError;

   int n_vec = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 iCLK = ~iCLK;

   // Wired-AND bus: a line is low if either side pulls it.
   assign w_ps2_clk  = dev_clk  & ~oPS2_clk_oe;
   assign w_ps2_data = dev_data & ~oPS2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iSend       (iSend),
      .iData       (iData),
      .iPS2_clk    (w_ps2_clk),
      .iPS2_data   (w_ps2_data),
      .oPS2_clk_oe (oPS2_clk_oe),
      .oPS2_data_oe(oPS2_data_oe),
      .oBusy       (oBusy),
      .oDone       (oDone),
      .oError      (oError)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         ones += int'(b[i]);
      end
      f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   always @(posedge iCLK) cyc <= cyc + 1;

   always @(negedge iCLK) begin
      if (!iRST) begin
         if (oDone)  n_done++;
         if (oError) n_err++;
         if (oDone || oError) begin
            check("pulse_busy_low", int'(oBusy), 0);
            check("pulse_exclusive", int'(oDone & oError), 0);
         end
         if (!oBusy) check("idle_lines_released", int'({oPS2_clk_oe, oPS2_data_oe}), 0);
      end
   end

   task automatic dev_frame(input bit ack, input int inj_fall, input int rst_fall,
                            input int half, output logic [10:0] got);
      int n;
      got = '0;
      n = 0;
      while (oPS2_clk_oe && !oPS2_data_oe && n < 4 * INH) begin
         n++;
         @(negedge iCLK);
      end
      check("inhibit_len", n, INH);
      n = 0;
      while (oPS2_clk_oe && oPS2_data_oe && n < 8) begin
         n++;
         @(negedge iCLK);
      end
      check("start_len", n, 1);
      check("clk_released", int'(oPS2_clk_oe), 0);
      for (int k = 1; k <= 11; k++) begin
         repeat (half) @(negedge iCLK);
         got[k-1] = w_ps2_data;
         if (k == 11 && ack) dev_data = 1'b0;
         dev_clk = 1'b0;
         if (k == rst_fall) begin
            repeat (5) @(negedge iCLK);
            iRST = 1'b1;
            @(negedge iCLK);
            iRST = 1'b0;
            check("rst_clk_oe", int'(oPS2_clk_oe), 0);
            check("rst_data_oe", int'(oPS2_data_oe), 0);
            check("rst_busy", int'(oBusy), 0);
            check("rst_done", int'(oDone), 0);
            check("rst_error", int'(oError), 0);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            return;
         end
         if (k == inj_fall) begin
            iData = 8'h00;
            iSend = 1'b1;
            @(negedge iCLK);
            iSend = 1'b0;
            repeat (half - 1) @(negedge iCLK);
         end else begin
            repeat (half) @(negedge iCLK);
         end
         dev_clk = 1'b1;
      end
      repeat (half) @(negedge iCLK);
      dev_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input int inj_fall,
                            input int rst_fall, input int half);
      int d0, e0;
      logic [10:0] got;
      d0 = n_done;
      e0 = n_err;
      iData = b;
      iSend = 1'b1;
      @(negedge iCLK);
      iSend = 1'b0;
      check("busy_set", int'(oBusy), 1);
      dev_frame(ack, inj_fall, rst_fall, half, got);
      if (rst_fall == 0) check("frame_bits", int'(got), int'(model_frame(b)));
      repeat (3 * half) @(negedge iCLK);
      check("done_count", n_done - d0, (ack && rst_fall == 0) ? 1 : 0);
      check("error_count", n_err - e0, (!ack && rst_fall == 0) ? 1 : 0);
      check("busy_end", int'(oBusy), 0);
      check("oe_end", int'({oPS2_clk_oe, oPS2_data_oe}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int a, n, d0, e0;
      iRST = 1'b1;
      iSend = 1'b0;
      iData = 8'h00;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge iCLK);
      check("reset_clk_oe", int'(oPS2_clk_oe), 0);
      check("reset_data_oe", int'(oPS2_data_oe), 0);
      check("reset_busy", int'(oBusy), 0);
      check("reset_done", int'(oDone), 0);
      check("reset_error", int'(oError), 0);
      iRST = 1'b0;
      repeat (5) @(negedge iCLK);

      run_frame(8'hED, 1'b1, 0, 0, 20);   // set-LEDs, parity 1
      run_frame(8'hF4, 1'b1, 0, 0, 20);   // enable, parity 0
      run_frame(8'h5A, 1'b0, 0, 0, 20);   // device omits ACK
      run_frame(8'hED, 1'b1, 3, 0, 20);   // iSend 0x00 mid-frame is ignored
      run_frame(8'h3C, 1'b1, 0, 4, 20);   // reset after 4th falling edge
      run_frame(8'hF4, 1'b1, 0, 0, 20);   // clean transfer after the reset

      // Device never clocks: error exactly TMO cycles after the accepting edge.
      d0 = n_done;
      e0 = n_err;
      a = cyc;
      iData = 8'h81;
      iSend = 1'b1;
      @(negedge iCLK);
      iSend = 1'b0;
      n = 0;
      while (!oError && n < TMO + 100) begin
         @(negedge iCLK);
         n++;
      end
      check("timeout_cycle", cyc - (a + 1), TMO);
      check("timeout_oe", int'({oPS2_clk_oe, oPS2_data_oe}), 0);
      check("timeout_busy", int'(oBusy), 0);
      repeat (10) @(negedge iCLK);
      check("timeout_err_count", n_err - e0, 1);
      check("timeout_done_count", n_done - d0, 0);

      for (int r = 0; r < 6; r++) begin
         logic [7:0] b;
         bit ack;
         int half;
         b    = 8'($urandom);
         ack  = ($urandom_range(0, 3) != 0);
         half = int'($urandom_range(12, 30));
         run_frame(b, ack, 0, 0, half);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
